// File: rtl/am2940_pkg.sv
// Shared definitions for the Am2940 address-generator datapath.
package am2940_pkg;

  localparam int unsigned AM2940_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_WC_ZERO  = 2'b00,
    MODE_WC_CMP   = 2'b01,
    MODE_ADDR_CMP = 2'b10,
    MODE_WC_CARRY = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SEL_WC = 2'b00,
    SEL_AC = 2'b01,
    SEL_CR = 2'b10,
    SEL_WR = 2'b11
  } sel_e;

endpackage

// File: rtl/am2940_updown_cnt.sv
// Loadable up/down counter with clear, gated counting and carry/borrow out.
module am2940_updown_cnt
  import am2940_pkg::*;
#(
  parameter int unsigned WIDTH = AM2940_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             ci_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             co_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             cnt_go;

  assign cnt_go = en_i & ci_i;

  // Priority: clear > load > increment > decrement > hold; inc and dec together hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_go && inc_i && !dec_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (cnt_go && dec_i && !inc_i) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign co_o  = cnt_go & ((inc_i & (cnt_q == '1)) | (dec_i & (cnt_q == '0)));

endmodule

// File: rtl/am2940_datapath.sv
// Am2940-style DMA address generator datapath: AR/WR/CR registers,
// AC/WC counters, transfer-complete flag and data-out mux.
module am2940_datapath
  import am2940_pkg::*;
#(
  parameter int unsigned WIDTH = AM2940_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] di,
  input  logic             plar,
  input  logic             plwr,
  input  logic             plcr,
  input  logic             plac,
  input  logic             plwc,
  input  logic             sela,
  input  logic             selw,
  input  logic             ena,
  input  logic             inca,
  input  logic             deca,
  input  logic             enw,
  input  logic             incw,
  input  logic             decw,
  input  logic             reswc,
  input  logic [1:0]       seldata,
  input  logic             oedata,
  input  logic             aci,
  input  logic             wci,
  output logic [WIDTH-1:0] do_data,
  output logic             do_oe,
  output logic [WIDTH-1:0] addr,
  output logic [2:0]       docr,
  output logic             aco,
  output logic             wco,
  output logic             done
);

  logic [WIDTH-1:0] ar_q;
  logic [WIDTH-1:0] wr_q;
  logic [2:0]       cr_q;
  logic             done_q;
  logic             done_d;
  logic [WIDTH-1:0] ac;
  logic [WIDTH-1:0] wc;
  logic             done_cond;
  logic             load_any;
  logic             wc_down;
  mode_e            mode;

  am2940_updown_cnt #(.WIDTH(WIDTH)) u_ac (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (1'b0),
    .load_i     (plac),
    .load_val_i (sela ? ar_q : di),
    .en_i       (ena),
    .ci_i       (aci),
    .inc_i      (inca),
    .dec_i      (deca),
    .cnt_o      (ac),
    .co_o       (aco)
  );

  am2940_updown_cnt #(.WIDTH(WIDTH)) u_wc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (reswc),
    .load_i     (plwc),
    .load_val_i (selw ? wr_q : di),
    .en_i       (enw),
    .ci_i       (wci),
    .inc_i      (incw),
    .dec_i      (decw),
    .cnt_o      (wc),
    .co_o       (wco)
  );

  // Plain holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q <= '0;
      wr_q <= '0;
      cr_q <= '0;
    end else begin
      if (plar) ar_q <= di;
      if (plwr) wr_q <= di;
      if (plcr) cr_q <= di[2:0];
    end
  end

  assign mode    = mode_e'(cr_q[1:0]);
  assign wc_down = enw & wci & decw & ~incw;

  // Terminal condition is judged on the registered counters, so done lags it
  // by one edge; any load clears it, otherwise it is sticky.
  always_comb begin
    load_any  = plar | plac | plwr | plwc | reswc | plcr;
    done_cond = 1'b0;
    case (mode)
      MODE_WC_ZERO:  done_cond = (wc == WIDTH'(1)) && wc_down;
      MODE_WC_CMP:   done_cond = (wc == wr_q);
      MODE_ADDR_CMP: done_cond = (ac == wr_q);
      MODE_WC_CARRY: done_cond = 1'b0;
      default:       done_cond = 1'b0;
    endcase
    done_d = load_any ? 1'b0 : (done_q | done_cond);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  // Data-out mux, forced to zero when not enabled.
  always_comb begin
    do_data = '0;
    if (oedata) begin
      case (sel_e'(seldata))
        SEL_WC:  do_data = wc;
        SEL_AC:  do_data = ac;
        SEL_CR:  do_data = {{(WIDTH-3){1'b0}}, cr_q};
        SEL_WR:  do_data = wr_q;
        default: do_data = '0;
      endcase
    end
  end

  assign do_oe = oedata;
  assign addr  = ac;
  assign docr  = cr_q;
  assign done  = done_q;

endmodule

// File: tb/tb_am2940_datapath.sv
// Directed self-checking bench for am2940_datapath.
module tb_am2940_datapath;

  logic       clk;
  logic       rst_n;
  logic [7:0] di;
  logic       plar, plwr, plcr, plac, plwc;
  logic       sela, selw;
  logic       ena, inca, deca;
  logic       enw, incw, decw;
  logic       reswc;
  logic [1:0] seldata;
  logic       oedata;
  logic       aci, wci;
  logic [7:0] do_data;
  logic       do_oe;
  logic [7:0] addr;
  logic [2:0] docr;
  logic       aco, wco, done;

  int unsigned tests;
  int unsigned fails;

  am2940_datapath #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .di      (di),
    .plar    (plar),
    .plwr    (plwr),
    .plcr    (plcr),
    .plac    (plac),
    .plwc    (plwc),
    .sela    (sela),
    .selw    (selw),
    .ena     (ena),
    .inca    (inca),
    .deca    (deca),
    .enw     (enw),
    .incw    (incw),
    .decw    (decw),
    .reswc   (reswc),
    .seldata (seldata),
    .oedata  (oedata),
    .aci     (aci),
    .wci     (wci),
    .do_data (do_data),
    .do_oe   (do_oe),
    .addr    (addr),
    .docr    (docr),
    .aco     (aco),
    .wco     (wco),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    plar = 0; plwr = 0; plcr = 0; plac = 0; plwc = 0;
    sela = 0; selw = 0;
    ena = 0; inca = 0; deca = 0;
    enw = 0; incw = 0; decw = 0;
    reswc = 0; aci = 0; wci = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [1:0] sel, input logic [7:0] exp, input string tag);
    seldata = sel;
    oedata  = 1'b1;
    #1;
    chk(tag, {24'd0, do_data}, {24'd0, exp});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    di = 8'h00; seldata = 2'b00; oedata = 1'b0;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    // 1: load everything, then async reset mid-cycle
    di = 8'hAA; plar = 1; plac = 1; plwr = 1; plwc = 1; plcr = 1;
    tick();
    chk("pre_reset_addr", {24'd0, addr}, 32'hAA);
    chk("pre_reset_docr", {29'd0, docr}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", {24'd0, addr}, 32'h0);
    chk("rst_docr", {29'd0, docr}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    chk("rst_aco",  {31'd0, aco}, 32'h0);
    chk("rst_wco",  {31'd0, wco}, 32'h0);
    peek(2'b11, 8'h00, "rst_wr");
    peek(2'b00, 8'h00, "rst_wc");
    oedata = 0;
    idle();
    @(negedge clk) rst_n = 1'b1;
    #1;

    // 2: load AR/AC, count up, reinitialise from AR
    di = 8'h10; plar = 1; plac = 1;
    tick();
    chk("load_ac", {24'd0, addr}, 32'h10);
    idle();
    ena = 1; aci = 1; inca = 1;
    tick(); chk("ac_up1", {24'd0, addr}, 32'h11);
    tick(); chk("ac_up2", {24'd0, addr}, 32'h12);
    tick(); chk("ac_up3", {24'd0, addr}, 32'h13);
    idle();
    plac = 1; sela = 1; di = 8'h77;
    tick();
    chk("ac_reinit", {24'd0, addr}, 32'h10);
    idle();

    // 3: mode 00, WC counts down to 1, done one edge later, sticky
    di = 8'h00; plcr = 1;
    tick();
    idle();
    di = 8'h03; plwc = 1;
    tick();
    idle();
    peek(2'b00, 8'h03, "m0_wc3");
    chk("m0_done0", {31'd0, done}, 32'h0);
    enw = 1; decw = 1; wci = 1; ena = 1; inca = 1; aci = 1;
    tick(); peek(2'b00, 8'h02, "m0_wc2"); chk("m0_done_wc2", {31'd0, done}, 32'h0);
    tick(); peek(2'b00, 8'h01, "m0_wc1"); chk("m0_done_wc1", {31'd0, done}, 32'h0);
    chk("m0_wco_wc1", {31'd0, wco}, 32'h0);
    tick(); peek(2'b00, 8'h00, "m0_wc0"); chk("m0_done_rise", {31'd0, done}, 32'h1);
    chk("m0_wco_wc0", {31'd0, wco}, 32'h1);
    tick(); chk("m0_done_sticky", {31'd0, done}, 32'h1);
    chk("m0_addr", {24'd0, addr}, 32'h14);
    idle();

    // 4: mode 10, AC compared against WR
    di = 8'h02; plcr = 1;
    tick(); idle();
    di = 8'h05; plwr = 1;
    tick(); idle();
    di = 8'h02; plac = 1;
    tick(); idle();
    chk("m2_done_load", {31'd0, done}, 32'h0);
    ena = 1; aci = 1; inca = 1;
    tick(); chk("m2_done_ac3", {31'd0, done}, 32'h0);
    tick(); chk("m2_done_ac4", {31'd0, done}, 32'h0);
    tick(); chk("m2_ac5", {24'd0, addr}, 32'h05);
    chk("m2_done_ac5", {31'd0, done}, 32'h0);
    tick(); chk("m2_done_rise", {31'd0, done}, 32'h1);
    tick(); chk("m2_done_sticky", {31'd0, done}, 32'h1);
    peek(2'b00, 8'hFF, "m2_wc_unchanged");
    idle();

    // 5: wrap and carry/borrow
    di = 8'h03; plcr = 1;
    tick(); idle();
    chk("m3_done_cleared", {31'd0, done}, 32'h0);
    di = 8'hFF; plac = 1;
    tick(); idle();
    ena = 1; aci = 1; inca = 1;
    aci = 0; #1;
    chk("aco_blocked", {31'd0, aco}, 32'h0);
    aci = 1; #1;
    chk("aco_ff", {31'd0, aco}, 32'h1);
    tick();
    chk("ac_wrap", {24'd0, addr}, 32'h00);
    chk("aco_after", {31'd0, aco}, 32'h0);
    deca = 1;
    tick();
    chk("ac_incdec_hold", {24'd0, addr}, 32'h00);
    idle();
    di = 8'h00; plwc = 1;
    tick(); idle();
    enw = 1; wci = 1; decw = 1; #1;
    chk("wco_00", {31'd0, wco}, 32'h1);
    tick();
    peek(2'b00, 8'hFF, "wc_wrap");
    idle();

    // 6: priorities and DO mux
    di = 8'h77; reswc = 1; plwc = 1; enw = 1; wci = 1; decw = 1;
    tick(); idle();
    peek(2'b00, 8'h00, "reswc_wins");
    di = 8'h02; plcr = 1;
    tick(); idle();
    di = 8'h09; plwr = 1;
    tick(); idle();
    di = 8'h09; plac = 1;
    tick(); idle();
    plac = 1; di = 8'h09;
    tick(); idle();
    chk("plac_beats_done", {31'd0, done}, 32'h0);
    tick();
    chk("done_after_load", {31'd0, done}, 32'h1);
    di = 8'h02; plcr = 1;
    tick(); idle();
    chk("plcr_clears_done", {31'd0, done}, 32'h0);
    di = 8'hA5; plwr = 1; tick(); idle();
    di = 8'h3C; plwc = 1; tick(); idle();
    di = 8'h5A; plac = 1; tick(); idle();
    di = 8'h06; plcr = 1; tick(); idle();
    peek(2'b00, 8'h3C, "do_wc");
    peek(2'b01, 8'h5A, "do_ac");
    peek(2'b10, 8'h06, "do_cr");
    peek(2'b11, 8'hA5, "do_wr");
    chk("docr", {29'd0, docr}, 32'h6);
    chk("do_oe_on", {31'd0, do_oe}, 32'h1);
    oedata = 0; #1;
    chk("do_off", {24'd0, do_data}, 32'h0);
    chk("do_oe_off", {31'd0, do_oe}, 32'h0);
    plwc = 1; selw = 1; di = 8'h11;
    tick(); idle();
    peek(2'b00, 8'hA5, "wc_reinit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
